branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage branch predictor for the rv32imc core: a bimodal 2-bit-counter table plus a direct-mapped branch target buffer (BTB). It predicts the outcome that the execute-stage comparator will later produce. It is trained by the resolved `br_en` result and target from execute, and it raises a registered mispredict/redirect to the fetch and flush logic.

## Interface
- `BHT_ENTRIES`, 64: number of 2-bit counters (power of two, ≥2)
- `BTB_ENTRIES`, 16: number of BTB entries (power of two, ≥2)
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `f_valid` input 1: fetch lookup request this cycle
- `f_pc` input 32: PC of the fetched instruction (halfword aligned)
- `flush` input 1: squash any in-flight prediction
- `p_valid` output 1: prediction valid (for the lookup of the previous cycle)
- `p_taken` output 1: predicted taken
- `p_target` output 32: predicted target (0 when `p_taken`=0)
- `u_valid` input 1: resolved conditional branch from execute
- `u_pc` input 32: PC of the resolved branch
- `u_taken` input 1: comparator result (`br_en`)
- `u_target` input 32: computed branch target
- `u_compressed` input 1: branch is a 16-bit encoding
- `u_pred_taken` input 1: prediction carried down the pipe with the branch
- `u_pred_target` input 32: predicted target carried down the pipe
- `mispredict` output 1: one-cycle pulse, redirect required
- `redirect_pc` output 32: correct next PC, valid while `mispredict`=1
- `perf_branches` output 32: resolved-branch count (saturating)
- `perf_mispredicts` output 32: mispredict count (saturating)

## Operation
- Counter index: `pc[log2(BHT_ENTRIES):1]`.
- BTB index: `pc[log2(BTB_ENTRIES):1]`. BTB tag: `pc[31:log2(BTB_ENTRIES)+1]`. Each entry holds a valid bit, the tag and a 32-bit target.
- Lookup rule: prediction is taken only if the BTB hits (valid and tag equal) and `counter[1]`=1. A BTB miss always predicts not-taken, whatever the counter value.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Counter update on `u_valid`: increment saturating at 11 if `u_taken`, else decrement saturating at 00.
- BTB update on `u_valid` && `u_taken`: write valid=1, tag and `u_target`, overwriting any existing entry (direct-mapped). Not-taken outcomes never modify the BTB.
- Mispredict condition: `u_valid` && ((`u_taken` != `u_pred_taken`) || (`u_taken` && `u_target` != `u_pred_target`)).
- Redirect PC: `u_target` if `u_taken`, else `u_pc`+2 if `u_compressed`, else `u_pc`+4 (modulo 2^32).
- Perf counters: `perf_branches` increments on every `u_valid`. `perf_mispredicts` increments on every mispredict. Both hold at 0xFFFFFFFF.

## Timing
- Reset (async assert, sync use after deassert):
  - all counters = 01, all BTB valid bits = 0
  - `p_valid`=0, `p_taken`=0, `p_target`=0
  - `mispredict`=0, `redirect_pc`=0
  - perf counters = 0
- Reset asserted mid-operation discards any pending prediction or redirect immediately.
- Lookup latency: 1 cycle. `f_valid`/`f_pc` sampled at edge N; `p_*` are registered and valid during cycle N+1.
- `p_valid` for a lookup is 0 if `flush` is high in the sampling cycle or in the following cycle.
- Update latency: 1 cycle. `u_*` sampled at edge N; tables are written at edge N, and `mispredict`/`redirect_pc` are registered and visible during cycle N+1.
- `mispredict` is a single-cycle pulse; back-to-back updates can produce consecutive pulses.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (read-before-write). The next-cycle lookup sees the new contents.
- `flush` does not affect updates, the tables or `mispredict`.

## Structure
- `rv32imc_types` gains:
  - `bht_ctr_t` (2-bit counter enum with the four named states)
  - `bp_pred_t` packed struct {taken, target}, used by fetch to carry the prediction down the pipe
  - localparam `BHT_RESET_CTR` = 01
- Sub-module `btb`: tag/target/valid arrays, combinational hit/target read, single write port, parameterised by `BTB_ENTRIES`.
- Counter table and perf counters stay in `branch_predictor`.

## Test plan
- Reset, then lookup of `f_pc`=0x0000_0100: `p_valid`=1, `p_taken`=0, `p_target`=0 in the next cycle.
- Train the branch at 0x100 taken to 0x80 (counter 01→10, BTB filled), then look up 0x100: `p_taken`=1, `p_target`=0x0000_0080.
- First training update carries `u_pred_taken`=0: `mispredict`=1 and `redirect_pc`=0x80 one cycle later. Next update with a matching prediction: `mispredict`=0.
- Not-taken branch at 0x200, `u_compressed`=1, predicted taken: `redirect_pc`=0x202. Repeat with `u_compressed`=0: `redirect_pc`=0x204.
- Saturation and aliasing:
  - Four taken updates leave the counter at 11.
  - One not-taken update leaves it at 10, so the prediction is still taken.
  - With `BTB_ENTRIES`=16, a taken branch at 0x100+0x20 evicts 0x100; lookup of 0x100 then predicts not-taken (tag mismatch).
- Same-cycle update and lookup of 0x100 returns the old value.
- `flush` in the cycle after a lookup forces `p_valid`=0.
- `rst_n` pulsed low while `mispredict`=1 clears it asynchronously.

Source files
------------

// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc fetch/branch-prediction path.
package rv32imc_types;

  // 2-bit bimodal counter; bit 1 is the taken/not-taken decision.
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } bht_ctr_t;

  // Prediction carried down the pipe alongside the fetched instruction.
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bp_pred_t;

  localparam bht_ctr_t BHT_RESET_CTR = CTR_WEAK_NT;

  // Saturating counter step toward the resolved outcome.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t n;
    n = c;
    case (c)
      CTR_STRONG_NT: n = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   n = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    n = taken ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  n = taken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       n = BHT_RESET_CTR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: combinational read, single write port.
module btb #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 31 - IDX_W;

  logic              valid  [ENTRIES];
  logic [TAG_W-1:0]  tag    [ENTRIES];
  logic [31:0]       target [ENTRIES];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [TAG_W-1:0]  wr_tag;

  // PCs are halfword aligned, so bit 0 carries no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = rd_pc[0] ^ wr_pc[0];

  assign rd_idx = rd_pc[IDX_W:1];
  assign wr_idx = wr_pc[IDX_W:1];
  assign rd_tag = rd_pc[31:IDX_W+1];
  assign wr_tag = wr_pc[31:IDX_W+1];

  // Read port: hit needs a valid entry with a matching tag.
  always_comb begin
    rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    rd_target = target[rd_idx];
  end

  // Valid bits: cleared on reset, set on every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload; only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal + BTB fetch-stage branch predictor with execute-stage training.
module branch_predictor
  import rv32imc_types::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        flush,
  output logic        p_valid,
  output logic        p_taken,
  output logic [31:0] p_target,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic        u_compressed,
  input  logic        u_pred_taken,
  input  logic [31:0] u_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t               bht [BHT_ENTRIES];
  logic [BHT_IDX_W-1:0]   f_idx;
  logic [BHT_IDX_W-1:0]   u_idx;
  bht_ctr_t               f_ctr;
  logic                   btb_hit;
  logic [31:0]            btb_target;
  bp_pred_t               lookup;
  bp_pred_t               pred_q;
  logic                   p_valid_q;
  logic                   mis_now;
  logic [31:0]            redir_now;

  assign f_idx = f_pc[BHT_IDX_W:1];
  assign u_idx = u_pc[BHT_IDX_W:1];
  assign f_ctr = bht[f_idx];

  btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (f_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (u_valid && u_taken),
    .wr_pc     (u_pc),
    .wr_target (u_target)
  );

  // Taken only when the BTB supplies a target and the counter leans taken.
  always_comb begin
    lookup = '0;
    if (btb_hit && f_ctr[1]) begin
      lookup.taken  = 1'b1;
      lookup.target = btb_target;
    end
  end

  // Resolve mispredict and the correct next PC from execute results.
  always_comb begin
    mis_now   = u_valid && ((u_taken != u_pred_taken) ||
                            (u_taken && (u_target != u_pred_target)));
    redir_now = u_taken ? u_target : (u_pc + (u_compressed ? 32'd2 : 32'd4));
  end

  // Counter table training; reads above see pre-update contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET_CTR;
    end else if (u_valid) begin
      bht[u_idx] <= ctr_next(bht[u_idx], u_taken);
    end
  end

  // Registered prediction for last cycle's lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      pred_q    <= '0;
    end else begin
      p_valid_q <= f_valid && !flush;
      pred_q    <= f_valid ? lookup : '0;
    end
  end

  // A flush in the result cycle must still squash, hence the late gate.
  assign p_valid  = p_valid_q && !flush;
  assign p_taken  = pred_q.taken;
  assign p_target = pred_q.target;

  // Registered redirect pulse toward fetch/flush logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mis_now;
      if (u_valid) redirect_pc <= redir_now;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (u_valid && (perf_branches != '1))
        perf_branches <= perf_branches + 32'd1;
      if (mis_now && (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule
